// File: rtl/spm_pkg.sv
// Shared definitions for the spm product deserialiser: FSM state encoding and default operand width.
package spm_pkg;

    localparam int unsigned SPM_N_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_bit_cnt.sv
// Serial bit counter with clear/load/increment control; done_c flags that the next
// increment is the terminal one (count == TERM-1).
module spm_bit_cnt #(
    parameter int unsigned TERM = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic done_c
);

    localparam int unsigned CW = $clog2(TERM + 1);

    logic [CW-1:0] cnt;

    // load marks the cycle that samples bit 0, so the count starts at 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done_c = (cnt == CW'(TERM - 1));

endmodule

// File: rtl/spm_prod_deser.sv
// Deserialises the LSB-first spm product stream into a 2N-bit word with a valid/ready hold stage.
// Optional parity output prod_par is enabled by defining SPM_DESER_PARITY_EN.
module spm_prod_deser
    import spm_pkg::*;
#(
    parameter int unsigned N = SPM_N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           p,
    input  logic           prod_ready,
    output logic [2*N-1:0] prod,
    output logic           prod_valid,
    output logic           busy,
    output logic           overrun
`ifdef SPM_DESER_PARITY_EN
    ,
    output logic           prod_par
`endif
);

    localparam int unsigned PW = 2 * N;

    spm_state_e    state;
    spm_state_e    state_nx;
    logic [PW-1:0] sr;
    logic [PW-1:0] sr_nx;
    logic          cnt_clr;
    logic          cnt_load;
    logic          cnt_inc;
    logic          cnt_done_c;
    logic          shift_en;
    logic          cap_en;
    logic          vld_clr;
    logic          ovr_set;

    assign sr_nx = {p, sr[PW-1:1]};

    spm_bit_cnt #(
        .TERM(PW)
    ) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .done_c(cnt_done_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; a start always wins over completing the current word
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                if (!start && cnt_done_c) state_nx = HOLD;
            end
            HOLD: begin
                if (prod_ready) state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        shift_en = 1'b0;
        cap_en   = 1'b0;
        vld_clr  = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    shift_en = 1'b1;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (start) begin
                    cnt_load = 1'b1;
                    ovr_set  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    cap_en  = cnt_done_c;
                end
            end
            HOLD: begin
                if (prod_ready) begin
                    vld_clr = 1'b1;
                    if (start) begin
                        cnt_load = 1'b1;
                        shift_en = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end else if (start) begin
                    ovr_set = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Shift register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (shift_en) sr <= sr_nx;
            if (cap_en) begin
                prod       <= sr_nx;
                prod_valid <= 1'b1;
            end else if (vld_clr) begin
                prod_valid <= 1'b0;
            end
            busy    <= (state_nx == SHIFT);
            overrun <= overrun | ovr_set;
        end
    end

`ifdef SPM_DESER_PARITY_EN
    // Parity of the captured word, updated together with prod
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_par <= 1'b0;
        end else if (cap_en) begin
            prod_par <= ^sr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_spm_prod_deser.sv
// Self-checking bench for spm_prod_deser (N=4): directed scenarios plus randomized stream vs. a word-level model.
module tb_spm_prod_deser;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          p = 1'b0;
    logic          prod_ready = 1'b0;
    logic [PW-1:0] prod;
    logic          prod_valid;
    logic          busy;
    logic          overrun;
`ifdef SPM_DESER_PARITY_EN
    logic          prod_par;
`endif

    int total = 0;
    int bad   = 0;

    spm_prod_deser #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .p         (p),
        .prod_ready(prod_ready),
        .prod      (prod),
        .prod_valid(prod_valid),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SPM_DESER_PARITY_EN
        ,
        .prod_par  (prod_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level reference: collects bits after each start, tracks holding and the sticky overrun
    logic [PW-1:0] exp_q[$];
    bit            m_cap;
    bit            m_hold;
    bit            m_ovr;
    int unsigned   m_k;
    logic [PW-1:0] m_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cap  = 1'b0;
            m_hold = 1'b0;
            m_ovr  = 1'b0;
            m_k    = 0;
            m_val  = '0;
            exp_q.delete();
        end else if (m_hold) begin
            if (prod_ready) begin
                m_hold = 1'b0;
                if (start) begin
                    m_cap = 1'b1;
                    m_val = PW'(p);
                    m_k   = 1;
                end
            end else if (start) begin
                m_ovr = 1'b1;
            end
        end else if (start) begin
            if (m_cap) m_ovr = 1'b1;
            m_cap = 1'b1;
            m_val = PW'(p);
            m_k   = 1;
        end else if (m_cap) begin
            if (p) m_val = m_val + (PW'(1) << m_k);
            m_k++;
            if (m_k == PW) begin
                exp_q.push_back(m_val);
                m_hold = 1'b1;
                m_cap  = 1'b0;
            end
        end
    end

    // Monitor: compare outputs against the model away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            chk("valid", PW'(prod_valid), PW'(m_hold));
            chk("busy", PW'(busy), PW'(m_cap));
            chk("overrun", PW'(overrun), PW'(m_ovr));
            if (prod_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: prod %h valid with no expected word at %0t", prod, $time);
                end else begin
                    chk("prod", prod, exp_q[0]);
`ifdef SPM_DESER_PARITY_EN
                    chk("par", PW'(prod_par), PW'(^exp_q[0]));
`endif
                    if (prod_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_prod"}, prod, '0);
        chk({nm, "_valid"}, PW'(prod_valid), '0);
        chk({nm, "_busy"}, PW'(busy), '0);
        chk({nm, "_ovr"}, PW'(overrun), '0);
`ifdef SPM_DESER_PARITY_EN
        chk({nm, "_par"}, PW'(prod_par), '0);
`endif
    endtask

    task automatic cyc(input logic s, input logic b, input logic r);
        start      = s;
        p          = b;
        prod_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [PW-1:0] w, input logic r);
        for (int i = 0; i < int'(PW); i++) cyc(i == 0, w[i], r);
    endtask

    // Asynchronous reset asserted mid-cycle, released one edge later
    task automatic do_reset(input string nm);
        start      = 1'b0;
        prod_ready = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero(nm);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_zero("por");
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic word, immediate acceptance
        send_word(8'h4D, 1'b1);
        chk("w4d_valid", PW'(prod_valid), PW'(1));
        chk("w4d_prod", prod, 8'h4D);
`ifdef SPM_DESER_PARITY_EN
        chk("w4d_par", PW'(prod_par), '0);
`endif
        cyc(1'b0, 1'b0, 1'b1);
        chk("w4d_pulse", PW'(prod_valid), '0);

        // Backpressure: held stable, then released back to idle
        send_word(8'h4C, 1'b0);
`ifdef SPM_DESER_PARITY_EN
        chk("w4c_par", PW'(prod_par), PW'(1));
`endif
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("bp_valid", PW'(prod_valid), PW'(1));
            chk("bp_prod", prod, 8'h4C);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("bp_rel_valid", PW'(prod_valid), '0);
        chk("bp_rel_busy", PW'(busy), '0);

        // Start coincident with handshake, then start during HOLD without ready
        do_reset("rst_a");
        send_word(8'h3C, 1'b0);
        send_word(8'h91, 1'b1);
        chk("bb_valid", PW'(prod_valid), PW'(1));
        chk("bb_prod", prod, 8'h91);
        chk("bb_ovr", PW'(overrun), '0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("hold_ovr", PW'(overrun), PW'(1));
        chk("hold_prod", prod, 8'h91);
        cyc(1'b0, 1'b0, 1'b1);
        chk("hold_rel", PW'(prod_valid), '0);

        // Restart at bit 3
        do_reset("rst_b");
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        send_word(8'h5A, 1'b0);
        chk("rs_prod", prod, 8'h5A);
        chk("rs_ovr", PW'(overrun), PW'(1));
        cyc(1'b0, 1'b0, 1'b1);

        // Reset mid-SHIFT and mid-HOLD, then a clean capture
        do_reset("rst_c");
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        do_reset("rst_shift");
        send_word(8'hC3, 1'b0);
        do_reset("rst_hold");
        send_word(8'h7E, 1'b1);
        chk("post_rst_prod", prod, 8'h7E);
        chk("post_rst_valid", PW'(prod_valid), PW'(1));
        cyc(1'b0, 1'b0, 1'b1);

        // Randomized stream: occasional restarts, random backpressure
        for (int blk = 0; blk < 6; blk++) begin
            do_reset("rst_rand");
            for (int c = 0; c < 400; c++) begin
                cyc($urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) < 7);
            end
        end

        cyc(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_prod_deser.md
SPM_PROD_DESER -- requirements
Module: spm_prod_deser

Interface
REQ-001 Parameter N, default 32, operand width of the spm multiplier; the product width is 2N.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous, active-low.
REQ-004 start  input  1  One-cycle pulse marking the cycle in which product bit 0 is present on p.
REQ-005 p  input  1  Serial product bit from spm, LSB first, one bit per cycle.
REQ-006 prod_ready  input  1  Downstream accepts prod when high with prod_valid.
REQ-007 prod  output  2N  Assembled parallel product.
REQ-008 prod_valid  output  1  prod holds a complete product.
REQ-009 busy  output  1  Capture in progress (state SHIFT).
REQ-010 overrun  output  1  Sticky flag: a start was lost or a capture was aborted.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-012 IDLE with start=1 SHALL load p into shift bit 2N-1, set bit count to 1, and go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL right-shift the register, insert p at bit 2N-1 and increment the count.
REQ-014 When the count reaches 2N, the FSM SHALL go to HOLD; bit k of prod SHALL equal the k-th serial bit after start.
REQ-015 prod_valid SHALL rise in the cycle after the 2N-th bit is sampled, so latency from start to prod_valid is 2N cycles.
REQ-016 In HOLD, prod and prod_valid SHALL stay stable until prod_valid and prod_ready are both high in the same cycle.
REQ-017 A handshake in HOLD with start=0 SHALL return the FSM to IDLE.
REQ-018 A handshake in HOLD with start=1 SHALL begin a new capture (REQ-012) with no bubble; overrun is unchanged.
REQ-019 start in HOLD without a handshake SHALL be ignored and SHALL set overrun.
REQ-020 start in SHIFT SHALL discard the partial word, restart the capture at bit 0 and set overrun.
REQ-021 start in the cycle that samples the 2N-th bit SHALL be treated as a restart (REQ-020).
REQ-022 overrun SHALL clear only on reset.
REQ-023 prod_ready SHALL be ignored outside HOLD.
REQ-024 busy SHALL be 1 exactly while the state is SHIFT.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, count 0, prod 0, prod_valid 0, busy 0 and overrun 0, including mid-capture or mid-HOLD.
REQ-026 The first start is honoured on the first rising edge at which rst is high.

Configuration
REQ-027 With SPM_DESER_PARITY_EN defined, an output prod_par (1 bit) SHALL equal the XOR of all bits of prod, registered alongside prod_valid, with reset value 0.
REQ-028 Without SPM_DESER_PARITY_EN, prod_par SHALL be absent from the port list and its logic SHALL be absent.

Structure
REQ-029 A shared package spm_pkg SHALL hold the state enum (IDLE/SHIFT/HOLD) and the default N constant.
REQ-030 The bit counter SHALL be a sub-module spm_bit_cnt, parameterised on the terminal count 2N, with a clear/load/inc interface and a done flag.
REQ-031 Shift register, FSM and output registers SHALL reside in spm_prod_deser.

Verification
REQ-032 N=4: start with serial bits 1,0,1,1,0,0,1,0 (LSB first) and prod_ready=1 -> prod=8'h4D and prod_valid high for exactly 1 cycle, 8 cycles after start.
REQ-033 N=4: complete word with prod_ready=0 for 5 cycles -> prod and prod_valid stable for 5 cycles, released on the first ready cycle, FSM back to IDLE.
REQ-034 N=4: start again at bit 3 of a capture -> capture restarts, overrun=1, the next prod equals the new stream only.
REQ-035 Start coincident with the HOLD handshake -> old word accepted, new word valid 8 cycles later, overrun stays 0; start in HOLD with ready=0 -> overrun=1.
REQ-036 rst low mid-SHIFT and again during HOLD -> all outputs 0 asynchronously; a following capture is correct.
REQ-037 With SPM_DESER_PARITY_EN and product 8'h4D -> prod_par=0; with 8'h4C -> prod_par=1.
